// File: rtl/udp_rx_port_demux_if.sv
// IPv4-to-UDP receive bus: l3 side from the IPv4 layer, l4 side to the application channels.
// The demux takes the slave view; the IPv4 source / channel sink take the master view.
interface udp_rx_port_demux_if #(
  parameter int NUM_PORTS = 4
);
  logic                 l3_start;
  logic                 l3_headers_valid;
  logic                 l3_protocol_is_udp;
  logic [15:0]          l3_payload_len;
  logic [31:0]          l3_src_ip;
  logic [15:0]          l3_pseudo_header_csum;
  logic                 l3_data_valid;
  logic [2:0]           l3_bytes_valid;
  logic [31:0]          l3_data;
  logic                 l3_commit;
  logic                 l3_drop;

  logic [NUM_PORTS-1:0] l4_start;
  logic [NUM_PORTS-1:0] l4_data_valid;
  logic [NUM_PORTS-1:0] l4_commit;
  logic [NUM_PORTS-1:0] l4_drop;
  logic [31:0]          l4_data;
  logic [2:0]           l4_bytes_valid;
  logic [31:0]          l4_src_ip;
  logic [15:0]          l4_src_port;
  logic [15:0]          l4_dst_port;
  logic [15:0]          l4_payload_len;

  modport master (
    output l3_start, l3_headers_valid, l3_protocol_is_udp, l3_payload_len, l3_src_ip,
           l3_pseudo_header_csum, l3_data_valid, l3_bytes_valid, l3_data, l3_commit, l3_drop,
    input  l4_start, l4_data_valid, l4_commit, l4_drop, l4_data, l4_bytes_valid,
           l4_src_ip, l4_src_port, l4_dst_port, l4_payload_len
  );

  modport slave (
    input  l3_start, l3_headers_valid, l3_protocol_is_udp, l3_payload_len, l3_src_ip,
           l3_pseudo_header_csum, l3_data_valid, l3_bytes_valid, l3_data, l3_commit, l3_drop,
    output l4_start, l4_data_valid, l4_commit, l4_drop, l4_data, l4_bytes_valid,
           l4_src_ip, l4_src_port, l4_dst_port, l4_payload_len
  );
endinterface

// File: rtl/udp_rx_port_demux.sv
// UDP receive demultiplexer: parses the UDP header, verifies checksum and length, and steers
// the payload to the lowest-indexed enabled channel whose port matches the destination port.
module udp_rx_port_demux #(
  parameter int NUM_PORTS     = 4,
  parameter bit ALLOW_NO_CSUM = 1'b1,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  udp_rx_port_demux_if.slave     bus,
  input  logic [16*NUM_PORTS-1:0] cfg_port_i,
  input  logic [NUM_PORTS-1:0]   cfg_port_en_i,
  output logic [CNT_WIDTH-1:0]   cnt_bad_csum_o,
  output logic [CNT_WIDTH-1:0]   cnt_no_port_o,
  output logic [CNT_WIDTH-1:0]   cnt_malformed_o
);

  localparam int CH_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_PORTS, S_LEN, S_BODY, S_PAD, S_DISCARD
  } state_t;

  state_t                 state_q;
  logic [CH_W-1:0]        ch_q;
  logic [15:0]            bytes_left_q;
  logic [15:0]            ip_len_q;
  logic [15:0]            csum_q;
  logic                   csum_zero_q;
  logic [NUM_PORTS-1:0]   start_q, dv_q, commit_q, drop_q;
  logic [31:0]            data_q;
  logic [2:0]             bv_q;
  logic [31:0]            src_ip_q;
  logic [15:0]            src_port_q, dst_port_q, payload_len_q;
  logic [CNT_WIDTH-1:0]   cnt_bad_q, cnt_np_q, cnt_mal_q;

  logic [15:0]            csum_d;
  logic [NUM_PORTS-1:0]   hit;
  logic [NUM_PORTS-1:0]   ch_onehot;
  logic [NUM_PORTS-1:0]   hit_onehot;
  logic                   hit_any;
  logic [CH_W-1:0]        hit_ch;
  logic [2:0]             take;
  logic                   csum_pass;
  logic                   abort;
  logic [15:0]            udp_len;

  function automatic logic [15:0] oc_add(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[15:0] + {15'd0, s[16]};
  endfunction

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PORTS; gi++) begin : g_port
      assign hit[gi]        = cfg_port_en_i[gi] && (cfg_port_i[16*gi +: 16] == dst_port_q);
      assign ch_onehot[gi]  = (ch_q == CH_W'(gi));
      assign hit_onehot[gi] = (hit_ch == CH_W'(gi));
    end
  endgenerate

  // Scan from the top so the lowest matching index is the one left standing.
  always_comb begin
    hit_any = 1'b0;
    hit_ch  = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (hit[i]) begin
        hit_any = 1'b1;
        hit_ch  = CH_W'(i);
      end
    end
  end

  assign csum_d    = oc_add(oc_add(csum_q, bus.l3_data[31:16]), bus.l3_data[15:0]);
  assign take      = (bytes_left_q < {13'd0, bus.l3_bytes_valid}) ? bytes_left_q[2:0] : bus.l3_bytes_valid;
  assign csum_pass = (csum_q == 16'hFFFF) || (ALLOW_NO_CSUM && csum_zero_q);
  assign abort     = bus.l3_drop || (bus.l3_start && (state_q != S_IDLE));
  assign udp_len   = bus.l3_data[31:16];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      ch_q          <= '0;
      bytes_left_q  <= '0;
      ip_len_q      <= '0;
      csum_q        <= '0;
      csum_zero_q   <= 1'b0;
      start_q       <= '0;
      dv_q          <= '0;
      commit_q      <= '0;
      drop_q        <= '0;
      data_q        <= '0;
      bv_q          <= '0;
      src_ip_q      <= '0;
      src_port_q    <= '0;
      dst_port_q    <= '0;
      payload_len_q <= '0;
      cnt_bad_q     <= '0;
      cnt_np_q      <= '0;
      cnt_mal_q     <= '0;
    end else begin
      start_q  <= '0;
      dv_q     <= '0;
      commit_q <= '0;
      drop_q   <= '0;

      if (bus.l3_data_valid && (state_q inside {S_PORTS, S_LEN, S_BODY, S_PAD, S_DISCARD}))
        csum_q <= csum_d;

      if (abort) begin
        // A channel only sees a drop once it has been told the packet started.
        if (state_q == S_BODY || state_q == S_PAD)
          drop_q <= ch_onehot;
        state_q <= bus.l3_start ? S_HDR : S_IDLE;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (bus.l3_start)
              state_q <= S_HDR;
          end
          S_HDR: begin
            if (bus.l3_headers_valid) begin
              csum_q   <= bus.l3_pseudo_header_csum;
              ip_len_q <= bus.l3_payload_len;
              if (!bus.l3_protocol_is_udp || bus.l3_payload_len < 16'd8)
                state_q <= S_IDLE;
              else
                state_q <= S_PORTS;
            end
          end
          S_PORTS: begin
            if (bus.l3_commit) begin
              cnt_mal_q <= sat_inc(cnt_mal_q);
              state_q   <= S_IDLE;
            end else if (bus.l3_data_valid) begin
              if (bus.l3_bytes_valid != 3'd4) begin
                cnt_mal_q <= sat_inc(cnt_mal_q);
                state_q   <= S_IDLE;
              end else begin
                src_port_q <= bus.l3_data[31:16];
                dst_port_q <= bus.l3_data[15:0];
                state_q    <= S_LEN;
              end
            end
          end
          S_LEN: begin
            if (bus.l3_commit) begin
              cnt_mal_q <= sat_inc(cnt_mal_q);
              state_q   <= S_IDLE;
            end else if (bus.l3_data_valid) begin
              csum_zero_q <= (bus.l3_data[15:0] == 16'h0000);
              if (bus.l3_bytes_valid != 3'd4 || udp_len < 16'd8 || udp_len > ip_len_q) begin
                cnt_mal_q <= sat_inc(cnt_mal_q);
                state_q   <= S_IDLE;
              end else if (hit_any) begin
                ch_q          <= hit_ch;
                start_q       <= hit_onehot;
                payload_len_q <= udp_len - 16'd8;
                bytes_left_q  <= udp_len - 16'd8;
                src_ip_q      <= bus.l3_src_ip;
                state_q       <= (udp_len == 16'd8) ? S_PAD : S_BODY;
              end else begin
                state_q <= S_DISCARD;
              end
            end
          end
          S_BODY: begin
            if (bus.l3_commit) begin
              drop_q    <= ch_onehot;
              cnt_mal_q <= sat_inc(cnt_mal_q);
              state_q   <= S_IDLE;
            end else if (bus.l3_data_valid) begin
              dv_q         <= ch_onehot;
              data_q       <= bus.l3_data;
              bv_q         <= take;
              bytes_left_q <= bytes_left_q - {13'd0, take};
              if (bytes_left_q == {13'd0, take})
                state_q <= S_PAD;
            end
          end
          S_PAD: begin
            if (bus.l3_commit) begin
              if (csum_pass) begin
                commit_q <= ch_onehot;
              end else begin
                drop_q    <= ch_onehot;
                cnt_bad_q <= sat_inc(cnt_bad_q);
              end
              state_q <= S_IDLE;
            end
          end
          S_DISCARD: begin
            if (bus.l3_commit) begin
              if (csum_pass)
                cnt_np_q <= sat_inc(cnt_np_q);
              state_q <= S_IDLE;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.l4_start       = start_q;
  assign bus.l4_data_valid  = dv_q;
  assign bus.l4_commit      = commit_q;
  assign bus.l4_drop        = drop_q;
  assign bus.l4_data        = data_q;
  assign bus.l4_bytes_valid = bv_q;
  assign bus.l4_src_ip      = src_ip_q;
  assign bus.l4_src_port    = src_port_q;
  assign bus.l4_dst_port    = dst_port_q;
  assign bus.l4_payload_len = payload_len_q;
  assign cnt_bad_csum_o     = cnt_bad_q;
  assign cnt_no_port_o      = cnt_np_q;
  assign cnt_malformed_o    = cnt_mal_q;

endmodule

// File: tb/tb_udp_rx_port_demux.sv
// Directed bench for udp_rx_port_demux: a packet builder pushes expected l4 events into a
// scoreboard queue and a negedge monitor pops and compares them as the DUT emits pulses.
module tb_udp_rx_port_demux;

  localparam int NP = 4;
  localparam logic [15:0] PSEUDO = 16'h1234;
  localparam logic [31:0] SRC_IP = 32'hC0A8_0001;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  udp_rx_port_demux_if #(.NUM_PORTS(NP)) bus_a ();
  udp_rx_port_demux_if #(.NUM_PORTS(NP)) bus_b ();

  logic [16*NP-1:0] cfg_port;
  logic [NP-1:0]    cfg_en;
  logic [15:0]      cnt_bad_a, cnt_np_a, cnt_mal_a;
  logic [15:0]      cnt_bad_b, cnt_np_b, cnt_mal_b;

  udp_rx_port_demux #(.NUM_PORTS(NP), .ALLOW_NO_CSUM(1'b1), .CNT_WIDTH(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a),
    .cfg_port_i(cfg_port), .cfg_port_en_i(cfg_en),
    .cnt_bad_csum_o(cnt_bad_a), .cnt_no_port_o(cnt_np_a), .cnt_malformed_o(cnt_mal_a)
  );

  udp_rx_port_demux #(.NUM_PORTS(NP), .ALLOW_NO_CSUM(1'b0), .CNT_WIDTH(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b),
    .cfg_port_i(cfg_port), .cfg_port_en_i(cfg_en),
    .cnt_bad_csum_o(cnt_bad_b), .cnt_no_port_o(cnt_np_b), .cnt_malformed_o(cnt_mal_b)
  );

  // The no-checksum-allowed build sees exactly the same l3 traffic.
  assign bus_b.l3_start              = bus_a.l3_start;
  assign bus_b.l3_headers_valid      = bus_a.l3_headers_valid;
  assign bus_b.l3_protocol_is_udp    = bus_a.l3_protocol_is_udp;
  assign bus_b.l3_payload_len        = bus_a.l3_payload_len;
  assign bus_b.l3_src_ip             = bus_a.l3_src_ip;
  assign bus_b.l3_pseudo_header_csum = bus_a.l3_pseudo_header_csum;
  assign bus_b.l3_data_valid         = bus_a.l3_data_valid;
  assign bus_b.l3_bytes_valid        = bus_a.l3_bytes_valid;
  assign bus_b.l3_data               = bus_a.l3_data;
  assign bus_b.l3_commit             = bus_a.l3_commit;
  assign bus_b.l3_drop               = bus_a.l3_drop;

  typedef struct packed {
    logic [1:0]  kind;   // 0 start, 1 data, 2 commit, 3 drop
    logic [3:0]  ch;
    logic [31:0] val;
    logic [2:0]  bv;
  } ev_t;

  ev_t  sbq[$];
  int   pass_cnt = 0;
  int   total_cnt = 0;
  int   b_commit = 0;
  int   b_drop = 0;
  logic [7:0] pay [0:63];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic push_ev(input int kind, input int ch, input logic [31:0] val, input int bv);
    ev_t e;
    e.kind = 2'(kind);
    e.ch   = 4'(ch);
    e.val  = val;
    e.bv   = 3'(bv);
    sbq.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  ev_t        mon_e;
  logic [3:0] mon_pv;
  always @(negedge clk) begin
    for (int c = 0; c < NP; c++) begin
      mon_pv = {bus_a.l4_start[c], bus_a.l4_data_valid[c], bus_a.l4_commit[c], bus_a.l4_drop[c]};
      for (int k = 0; k < 4; k++) begin
        if (mon_pv[3-k] === 1'b1) begin
          check("sb_has_event", 32'(sbq.size() != 0), 32'd1);
          if (sbq.size() != 0) begin
            mon_e = sbq.pop_front();
            $display("event kind=%0d ch=%0d data=%h bv=%0d plen=%0d", k, c,
                     bus_a.l4_data, bus_a.l4_bytes_valid, bus_a.l4_payload_len);
            check("ev_kind_ch", 32'(k * 16 + c), 32'(mon_e.kind) * 16 + 32'(mon_e.ch));
            if (k == 1) begin
              check("ev_data", bus_a.l4_data, mon_e.val);
              check("ev_bytes_valid", 32'(bus_a.l4_bytes_valid), 32'(mon_e.bv));
            end else if (k == 0) begin
              check("ev_payload_len", 32'(bus_a.l4_payload_len), mon_e.val);
            end
          end
        end
      end
    end
    b_commit += $countones(bus_b.l4_commit);
    b_drop   += $countones(bus_b.l4_drop);
  end

  // Builds a UDP datagram from pay[], pushes the expected l4 events, then drives it.
  // csum_mode: 0 correct, 1 correct then a payload bit flipped, 2 field forced to 0x0000.
  // abort_after: payload words sent before aborting (-1 none); abort_kind 1 = l3_drop, 2 = reset.
  task automatic send_pkt(input logic [15:0] sport, input logic [15:0] dport,
                          input logic [15:0] ulen, input logic [15:0] l3len,
                          input int csum_mode, input int abort_after, input int abort_kind);
    logic [31:0] w [0:17];
    logic [2:0]  bvs [0:17];
    logic [31:0] acc;
    logic [15:0] field;
    int nb, nw, ch, left, n;
    bit ok, pass;

    nb = int'(l3len) - 8;
    nw = 2 + (nb + 3) / 4;
    w[0] = {sport, dport};  bvs[0] = 3'd4;
    w[1] = {ulen, 16'h0};   bvs[1] = 3'd4;
    for (int i = 0; i < (nb + 3) / 4; i++) begin
      w[2+i] = 32'h0;
      for (int b = 0; b < 4; b++)
        if (4 * i + b < nb) w[2+i][31-8*b -: 8] = pay[4*i+b];
      bvs[2+i] = (nb - 4 * i >= 4) ? 3'd4 : 3'(nb - 4 * i);
    end

    acc = 32'(PSEUDO);
    for (int i = 0; i < nw; i++) acc = acc + 32'(w[i][31:16]) + 32'(w[i][15:0]);
    while (acc[31:16] != 16'h0) acc = {16'h0, acc[15:0]} + {16'h0, acc[31:16]};
    field = ~acc[15:0];
    if (field == 16'h0) field = 16'hFFFF;
    if (csum_mode == 2) field = 16'h0;
    w[1][15:0] = field;
    if (csum_mode == 1) w[2][0] = ~w[2][0];

    acc = 32'(PSEUDO);
    for (int i = 0; i < nw; i++) acc = acc + 32'(w[i][31:16]) + 32'(w[i][15:0]);
    while (acc[31:16] != 16'h0) acc = {16'h0, acc[15:0]} + {16'h0, acc[31:16]};
    pass = (acc[15:0] == 16'hFFFF) || (field == 16'h0);

    ok = (ulen >= 16'd8) && (ulen <= l3len);
    ch = -1;
    for (int i = NP - 1; i >= 0; i--)
      if (cfg_en[i] && cfg_port[16*i +: 16] == dport) ch = i;
    if (ok && ch >= 0) begin
      push_ev(0, ch, 32'(ulen - 16'd8), 0);
      left = int'(ulen) - 8;
      for (int i = 2; i < nw; i++) begin
        if (abort_after >= 0 && i - 2 >= abort_after) break;
        if (left > 0) begin
          n = (left < int'(bvs[i])) ? left : int'(bvs[i]);
          push_ev(1, ch, w[i], n);
          left -= n;
        end
      end
      if (abort_after >= 0) begin
        if (abort_kind == 1) push_ev(3, ch, 32'h0, 0);
      end else begin
        push_ev(pass ? 2 : 3, ch, 32'h0, 0);
      end
    end
    $display("packet sport=%0d dport=%0d ulen=%0d l3len=%0d csum=%h mode=%0d abort=%0d/%0d",
             sport, dport, ulen, l3len, field, csum_mode, abort_after, abort_kind);

    bus_a.l3_start = 1'b1;
    tick();
    bus_a.l3_start = 1'b0;
    bus_a.l3_headers_valid      = 1'b1;
    bus_a.l3_protocol_is_udp    = 1'b1;
    bus_a.l3_payload_len        = l3len;
    bus_a.l3_src_ip             = SRC_IP;
    bus_a.l3_pseudo_header_csum = PSEUDO;
    tick();
    bus_a.l3_headers_valid = 1'b0;
    for (int i = 0; i < nw; i++) begin
      if (abort_after >= 0 && i - 2 == abort_after) break;
      bus_a.l3_data_valid  = 1'b1;
      bus_a.l3_data        = w[i];
      bus_a.l3_bytes_valid = bvs[i];
      tick();
    end
    bus_a.l3_data_valid  = 1'b0;
    bus_a.l3_data        = 32'h0;
    bus_a.l3_bytes_valid = 3'd0;
    if (abort_after < 0) begin
      bus_a.l3_commit = 1'b1;
      tick();
      bus_a.l3_commit = 1'b0;
    end else if (abort_kind == 1) begin
      bus_a.l3_drop = 1'b1;
      tick();
      bus_a.l3_drop = 1'b0;
    end else begin
      @(negedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("rst_mid_pulses", {bus_a.l4_start, bus_a.l4_data_valid, bus_a.l4_commit, bus_a.l4_drop}, 32'h0);
      check("rst_mid_data", bus_a.l4_data, 32'h0);
      check("rst_mid_bv", 32'(bus_a.l4_bytes_valid), 32'h0);
      check("rst_mid_plen_ports", {bus_a.l4_payload_len, bus_a.l4_src_port}, 32'h0);
      check("rst_mid_src_ip", bus_a.l4_src_ip, 32'h0);
      check("rst_mid_counters", {cnt_bad_a, cnt_mal_a}, 32'h0);
      tick();
      rst_n = 1'b1;
    end
    tick();
    tick();
  endtask

  initial begin
    bus_a.l3_start = 1'b0;             bus_a.l3_headers_valid = 1'b0;
    bus_a.l3_protocol_is_udp = 1'b0;   bus_a.l3_payload_len = 16'h0;
    bus_a.l3_src_ip = 32'h0;           bus_a.l3_pseudo_header_csum = 16'h0;
    bus_a.l3_data_valid = 1'b0;        bus_a.l3_bytes_valid = 3'd0;
    bus_a.l3_data = 32'h0;             bus_a.l3_commit = 1'b0;
    bus_a.l3_drop = 1'b0;
    cfg_port = {16'd0, 16'd0, 16'd67, 16'd53};
    cfg_en   = 4'b0011;

    #1 rst_n = 1'b0;
    #1;
    check("reset_pulses", {bus_a.l4_start, bus_a.l4_data_valid, bus_a.l4_commit, bus_a.l4_drop}, 32'h0);
    check("reset_data", bus_a.l4_data, 32'h0);
    check("reset_counters", {cnt_bad_a, cnt_np_a}, 32'h0);
    check("reset_malformed", 32'(cnt_mal_a), 32'h0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Matched port 67 -> channel 1, 5-byte payload.
    pay[0] = 8'hDE; pay[1] = 8'hAD; pay[2] = 8'hBE; pay[3] = 8'hEF; pay[4] = 8'h42;
    send_pkt(16'd1234, 16'd67, 16'd13, 16'd13, 0, -1, 0);
    check("src_port", 32'(bus_a.l4_src_port), 32'd1234);
    check("dst_port", 32'(bus_a.l4_dst_port), 32'd67);
    check("src_ip", bus_a.l4_src_ip, SRC_IP);
    check("payload_len", 32'(bus_a.l4_payload_len), 32'd5);

    send_pkt(16'd1234, 16'd67, 16'd13, 16'd13, 1, -1, 0);
    check("cnt_bad_csum_after_flip", 32'(cnt_bad_a), 32'd1);

    begin
      int bc0, bd0;
      logic [15:0] bb0;
      bc0 = b_commit; bd0 = b_drop; bb0 = cnt_bad_b;
      send_pkt(16'd1234, 16'd67, 16'd13, 16'd13, 2, -1, 0);
      check("nocsum_strict_commits", 32'(b_commit - bc0), 32'd0);
      check("nocsum_strict_drops", 32'(b_drop - bd0), 32'd1);
      check("nocsum_strict_bad_cnt", 32'(cnt_bad_b - bb0), 32'd1);
      check("nocsum_allowed_bad_cnt", 32'(cnt_bad_a), 32'd1);
    end

    send_pkt(16'd1234, 16'd9999, 16'd13, 16'd13, 0, -1, 0);
    check("cnt_no_port", 32'(cnt_np_a), 32'd1);

    cfg_port = {16'd0, 16'd0, 16'd53, 16'd53};
    tick();
    send_pkt(16'd5353, 16'd53, 16'd13, 16'd13, 0, -1, 0);
    cfg_port = {16'd0, 16'd0, 16'd67, 16'd53};
    tick();

    send_pkt(16'd1, 16'd67, 16'd40, 16'd20, 0, -1, 0);
    check("cnt_malformed_len_gt_ip", 32'(cnt_mal_a), 32'd1);
    send_pkt(16'd1, 16'd67, 16'd7, 16'd15, 0, -1, 0);
    check("cnt_malformed_len_lt_8", 32'(cnt_mal_a), 32'd2);
    check("cnt_no_port_unchanged", 32'(cnt_np_a), 32'd1);

    for (int i = 0; i < 10; i++) pay[i] = 8'(8'h10 + 8'(i * 7));
    send_pkt(16'd7, 16'd67, 16'd18, 16'd18, 0, 1, 1);
    send_pkt(16'd7, 16'd67, 16'd18, 16'd18, 0, -1, 0);
    check("cnt_malformed_after_drop", 32'(cnt_mal_a), 32'd2);
    check("cnt_bad_after_drop", 32'(cnt_bad_a), 32'd1);

    send_pkt(16'd8, 16'd67, 16'd18, 16'd18, 0, 1, 2);
    send_pkt(16'd9, 16'd53, 16'd18, 16'd18, 0, -1, 0);
    check("post_reset_src_port", 32'(bus_a.l4_src_port), 32'd9);
    check("post_reset_counters", {cnt_bad_a, cnt_mal_a}, 32'h0);

    repeat (4) tick();
    check("scoreboard_drained", 32'(sbq.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/udp_rx_port_demux.md
Name: udp_rx_port_demux

Overview:
- Parametrised successor to the single-consumer UDP receive path.
- Sits between the IPv4 receive bus and up to NUM_PORTS application channels.
- Parses the UDP header, matches the destination port against a configurable port table, and forwards the payload to the matching channel only.
- Verifies the UDP checksum (zero checksum optionally accepted), enforces length consistency, and keeps saturating drop counters.

Parameters:
NUM_PORTS, 4, number of application channels / port-table entries (1..16)
ALLOW_NO_CSUM, 1, 1 = UDP checksum field 0x0000 means "not computed" and the packet is accepted unverified
CNT_WIDTH, 16, width of each saturating statistics counter

Ports:
clk  in  1  single clock; all logic on rising edge
rst_n  in  1  asynchronous, active-low reset
cfg_port  in  16*NUM_PORTS  port table; entry i = bits [16i+15:16i]; sampled at LEN state
cfg_port_en  in  NUM_PORTS  enable per table entry
l3_start  in  1  new IPv4 packet
l3_headers_valid  in  1  IPv4 header fields valid this cycle
l3_protocol_is_udp  in  1  protocol field == 17
l3_payload_len  in  16  IPv4 payload bytes
l3_src_ip  in  32  source address
l3_pseudo_header_csum  in  16  ones-complement pseudo-header sum
l3_data_valid  in  1  data word valid
l3_bytes_valid  in  3  valid bytes (1..4), MSB-aligned; unused bytes are zero
l3_data  in  32  payload word, big-endian
l3_commit  in  1  end of packet, IPv4 layer OK; never coincident with l3_data_valid
l3_drop  in  1  abort from IPv4 layer
l4_start  out  NUM_PORTS  one-hot start pulse
l4_data_valid  out  NUM_PORTS  one-hot data strobe
l4_commit  out  NUM_PORTS  one-hot commit pulse
l4_drop  out  NUM_PORTS  one-hot drop pulse
l4_data  out  32  shared payload word
l4_bytes_valid  out  3  shared valid-byte count
l4_src_ip  out  32  latched source address
l4_src_port  out  16  latched source port
l4_dst_port  out  16  latched destination port
l4_payload_len  out  16  UDP length − 8
cnt_bad_csum  out  CNT_WIDTH  checksum failures
cnt_no_port  out  CNT_WIDTH  valid UDP packets with no port match
cnt_malformed  out  CNT_WIDTH  length / truncation failures

Behaviour:
- Reset: all outputs, counters and state go to 0 / IDLE immediately on rst_n low.
- Pulse outputs (start, data_valid, commit, drop) are single-cycle and default to 0 every cycle.
- All outputs are registered. Latency from l3 input to the corresponding l4 output is 1 cycle.

Checksum:
- 16-bit ones-complement accumulator.
- Loaded with l3_pseudo_header_csum on l3_headers_valid.
- On each l3_data_valid, adds data[31:16] and data[15:0] with end-around carry. The checksum field is included.
- A packet passes when the final sum is 0xFFFF, or when the header checksum is 0x0000 and ALLOW_NO_CSUM = 1.

State machine (states and transitions):
- IDLE: on l3_start → HDR.
- HDR: on l3_headers_valid:
  - if !udp or payload_len < 8 → IDLE, silent, no counter increment.
  - otherwise → PORTS.
- PORTS: on data_valid:
  - if bytes_valid != 4 → IDLE, cnt_malformed++.
  - otherwise latch src/dst port → LEN.
- LEN: on data_valid, with len = data[31:16]:
  - if bytes_valid != 4, len < 8, or len > l3_payload_len → IDLE, cnt_malformed++.
  - otherwise match dst_port against the enabled entries; the lowest index wins:
    - match: latch channel, pulse l4_start[ch], payload_len = len − 8, bytes_left = len − 8, latch src_ip → BODY. If len == 8 → PAD instead.
    - no match → DISCARD.
- BODY: on data_valid:
  - pulse l4_data_valid[ch]; l4_data = l3_data.
  - l4_bytes_valid = min(bytes_left, l3_bytes_valid).
  - bytes_left −= that value; at 0 → PAD.
  - l3_commit in BODY: truncated; pulse l4_drop[ch], cnt_malformed++ → IDLE.
- PAD: ignore data except for the checksum. On l3_commit:
  - checksum pass → pulse l4_commit[ch].
  - checksum fail → pulse l4_drop[ch], cnt_bad_csum++.
  - → IDLE.
- DISCARD: on l3_commit → cnt_no_port++ (only if the checksum passed) → IDLE.

Boundary conditions:
- l3_drop in any state → IDLE. l4_drop[ch] pulses only if l4_start was already issued (BODY/PAD).
- l3_start while not IDLE: abort as for l3_drop (including the l4_drop rule), then go to HDR the same cycle.
- l3_drop has priority over a simultaneous l3_commit.
- cfg_port changes outside LEN have no effect on a packet in flight.
- Counters saturate at all-ones and never wrap.

Test Plan:
- Port table {53, 67, 0, 0}, en = 0011; UDP dst 67, len 13, 5-byte payload, valid checksum → l4_start[1]; two l4_data_valid[1] with bytes_valid 4 then 1; l4_commit[1]; payload_len = 5.
- Same packet with one payload bit flipped → l4_drop[1] at commit, cnt_bad_csum = 1; no l4_commit.
- Checksum field 0x0000 with ALLOW_NO_CSUM = 1 → l4_commit. Rebuild with ALLOW_NO_CSUM = 0 → l4_drop.
- dst 9999 (unmatched), valid packet → no l4 pulses, cnt_no_port = 1. Duplicate table entries {53, 53} → channel 0 only.
- UDP len 40 with l3_payload_len 20 → no start, cnt_malformed = 1. UDP len 7 → same.
- l3_drop mid-BODY → l4_drop[ch] once, IDLE next cycle. rst_n low mid-BODY → all outputs 0 asynchronously; the next packet is processed normally.
